// File: rtl/axi_stream_pkg.sv
// axi_stream_pkg: shared stream-width defaults and lane-index sizing for the width converters.
package axi_stream_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int RATIO_DEF = 4;

    function automatic int idx_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage

// File: rtl/axi_width_up_oreg.sv
// axi_width_up_oreg: output holding register; loads a packed beat and drains it on downstream ready.
module axi_width_up_oreg #(
    parameter int W = 64,
    parameter int R = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic [R-1:0] i_keep,
    input  logic         i_last,
    input  logic         i_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic [R-1:0] o_keep,
    output logic         o_last
);

    logic         vld_d, vld_q;
    logic [W-1:0] data_d, data_q;
    logic [R-1:0] keep_d, keep_q;
    logic         last_d, last_q;

    // A load may coincide with a drain, keeping vld high with no bubble.
    always_comb begin
        vld_d  = i_load | (vld_q & ~i_rdy);
        data_d = i_load ? i_data : data_q;
        keep_d = i_load ? i_keep : keep_q;
        last_d = i_load ? i_last : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign o_vld  = vld_q;
    assign o_data = data_q;
    assign o_keep = keep_q;
    assign o_last = last_q;

endmodule

// File: rtl/axi_width_up.sv
// axi_width_up: packs RATIO narrow words into one wide beat with keep/last and a packet counter.
module axi_width_up
    import axi_stream_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int RATIO = RATIO_DEF
) (
    input  logic                   ar_clk,
    input  logic                   ar_rst_n,
    input  logic                   i_s_vld,
    input  logic [DSIZE-1:0]       i_s_data,
    input  logic                   i_s_last,
    output logic                   o_s_rdy,
    output logic                   o_m_vld,
    output logic [DSIZE*RATIO-1:0] o_m_data,
    output logic [RATIO-1:0]       o_m_keep,
    output logic                   o_m_last,
    input  logic                   i_m_rdy,
    output logic [15:0]            o_pkt_cnt
);

    localparam int IW = idx_w(RATIO);
    localparam int W  = DSIZE * RATIO;

    logic [1:0]    rst_sync_d, rst_sync_q;
    logic          rst_n;
    logic [IW-1:0] idx_d, idx_q;
    logic [W-1:0]  acc_d, acc_q;
    logic [15:0]   pkt_cnt_d, pkt_cnt_q;
    logic          s_xfer, done, s_last;
    logic [W-1:0]  beat_data;
    logic [RATIO-1:0] beat_keep;

    // Reset asserts asynchronously and releases two clock edges later.
    always_ff @(posedge ar_clk or negedge ar_rst_n) begin
        if (!ar_rst_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // The accumulator only ever holds lanes below idx, so OR-ing the new word keeps upper lanes zero.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
        s_last     = i_s_vld & i_s_last;
        o_s_rdy    = rst_n & (~o_m_vld | i_m_rdy | (idx_q != IW'(RATIO-1) & ~s_last));
        s_xfer     = i_s_vld & o_s_rdy;
        done       = s_xfer & (idx_q == IW'(RATIO-1) | i_s_last);
        beat_data  = acc_q | (W'(i_s_data) << (DSIZE * int'(idx_q)));
        beat_keep  = RATIO'((1 << (int'(idx_q) + 1)) - 1);
        acc_d      = done ? '0 : s_xfer ? beat_data : acc_q;
        idx_d      = done ? '0 : s_xfer ? idx_q + 1'b1 : idx_q;
        pkt_cnt_d  = pkt_cnt_q + {15'd0, o_m_vld & i_m_rdy & o_m_last};
    end

    always_ff @(posedge ar_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            acc_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_pkt_cnt = pkt_cnt_q;

    axi_width_up_oreg #(.W(W), .R(RATIO)) u_oreg (
        .clk    (ar_clk),
        .rst_n  (rst_n),
        .i_load (done),
        .i_data (beat_data),
        .i_keep (beat_keep),
        .i_last (i_s_last),
        .i_rdy  (i_m_rdy),
        .o_vld  (o_m_vld),
        .o_data (o_m_data),
        .o_keep (o_m_keep),
        .o_last (o_m_last)
    );

endmodule
